// File: rtl/face_det_pkg.sv
// Shared types and constants for the skin-pixel bounding-box tracker.
// Holds the RGB field positions, coordinate/count widths and the tracker FSM states.
package face_det_pkg;

  localparam int COORD_W = 11;
  localparam int COUNT_W = 19;

  localparam int R_HI = 11;
  localparam int R_LO = 8;
  localparam int G_HI = 7;
  localparam int G_LO = 4;
  localparam int B_HI = 3;
  localparam int B_LO = 0;

  localparam logic [COORD_W-1:0] COORD_MAX = '1;
  localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

  typedef enum logic [1:0] {
    SYNC   = 2'd0,
    ARMED  = 2'd1,
    ACCUM  = 2'd2,
    COMMIT = 2'd3
  } track_state_e;

  // Inclusive extent of a [lo, hi] coordinate range.
  function automatic logic [COORD_W-1:0] span(input logic [COORD_W-1:0] lo,
                                              input logic [COORD_W-1:0] hi);
    return hi - lo + 11'd1;
  endfunction

endpackage

// File: rtl/skin_classifier.sv
// Registered first stage: classifies one RGB444 pixel as skin and delays the
// VGA timing by one cycle so it stays aligned with the skin bit.
module skin_classifier
  import face_det_pkg::*;
#(
  parameter int R_MIN     = 6,
  parameter int RG_MARGIN = 2,
  parameter int RB_MARGIN = 3
) (
  input  logic               pclk,
  input  logic [11:0]        rgb_in,
  input  logic [COORD_W-1:0] hcount_in,
  input  logic [COORD_W-1:0] vcount_in,
  input  logic               hblnk_in,
  input  logic               vblnk_in,
  output logic               skin_p1,
  output logic [COORD_W-1:0] hcount_p1,
  output logic [COORD_W-1:0] vcount_p1,
  output logic               hblnk_p1,
  output logic               vblnk_p1
);

  // Five bits so that G + margin and B + margin can never wrap.
  localparam logic [4:0] R_MIN5 = 5'(R_MIN);
  localparam logic [4:0] RG5    = 5'(RG_MARGIN);
  localparam logic [4:0] RB5    = 5'(RB_MARGIN);

  logic [4:0]         r5, g5_margin, b5_margin;
  logic               skin_p1_d, skin_p1_q;
  logic [COORD_W-1:0] hcount_p1_d, hcount_p1_q;
  logic [COORD_W-1:0] vcount_p1_d, vcount_p1_q;
  logic               hblnk_p1_d, hblnk_p1_q;
  logic               vblnk_p1_d, vblnk_p1_q;

  always_comb begin
    r5          = {1'b0, rgb_in[R_HI:R_LO]};
    g5_margin   = {1'b0, rgb_in[G_HI:G_LO]} + RG5;
    b5_margin   = {1'b0, rgb_in[B_HI:B_LO]} + RB5;
    skin_p1_d   = (r5 >= R_MIN5) && (r5 > g5_margin) && (r5 > b5_margin);
    hcount_p1_d = hcount_in;
    vcount_p1_d = vcount_in;
    hblnk_p1_d  = hblnk_in;
    vblnk_p1_d  = vblnk_in;
  end

  // stage 0 -> stage 1
  always_ff @(posedge pclk) begin
    skin_p1_q   <= skin_p1_d;
    hcount_p1_q <= hcount_p1_d;
    vcount_p1_q <= vcount_p1_d;
    hblnk_p1_q  <= hblnk_p1_d;
    vblnk_p1_q  <= vblnk_p1_d;
  end

  assign skin_p1   = skin_p1_q;
  assign hcount_p1 = hcount_p1_q;
  assign vcount_p1 = vcount_p1_q;
  assign hblnk_p1  = hblnk_p1_q;
  assign vblnk_p1  = vblnk_p1_q;

endmodule

// File: rtl/face_bbox_tracker.sv
// Per-frame skin bounding-box tracker: accumulates skin-pixel extents over a frame
// and publishes the box, count and detect flag during vertical blanking.
module face_bbox_tracker
  import face_det_pkg::*;
#(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int MIN_PIXELS = 256,
  parameter int R_MIN      = 6,
  parameter int RG_MARGIN  = 2,
  parameter int RB_MARGIN  = 3
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic [10:0] hcount_in,
  input  logic [10:0] vcount_in,
  input  logic        hblnk_in,
  input  logic        vblnk_in,
  input  logic [11:0] rgb_in,
  output logic [10:0] rect_x,
  output logic [10:0] rect_y,
  output logic [10:0] rect_w,
  output logic [10:0] rect_h,
  output logic [18:0] pixel_count,
  output logic        detected_flag,
  output logic        frame_done
);

  localparam logic [COORD_W-1:0] H_LIM   = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] V_LIM   = COORD_W'(V_ACTIVE);
  localparam logic [COUNT_W-1:0] MIN_CNT = COUNT_W'(MIN_PIXELS);

  logic               skin_p1;
  logic [COORD_W-1:0] hcount_p1, vcount_p1;
  logic               hblnk_p1, vblnk_p1;

  skin_classifier #(
    .R_MIN     (R_MIN),
    .RG_MARGIN (RG_MARGIN),
    .RB_MARGIN (RB_MARGIN)
  ) u_skin_classifier (
    .pclk      (pclk),
    .rgb_in    (rgb_in),
    .hcount_in (hcount_in),
    .vcount_in (vcount_in),
    .hblnk_in  (hblnk_in),
    .vblnk_in  (vblnk_in),
    .skin_p1   (skin_p1),
    .hcount_p1 (hcount_p1),
    .vcount_p1 (vcount_p1),
    .hblnk_p1  (hblnk_p1),
    .vblnk_p1  (vblnk_p1)
  );

  track_state_e       state_d, state_q;
  logic               vblnk_prev_q;
  logic               vblnk_rise, vblnk_fall, pix_valid;
  logic [COORD_W-1:0] min_x_d, min_x_q, min_y_d, min_y_q;
  logic [COORD_W-1:0] max_x_d, max_x_q, max_y_d, max_y_q;
  logic [COUNT_W-1:0] count_d, count_q;
  logic [COORD_W-1:0] rect_x_d, rect_x_q, rect_y_d, rect_y_q;
  logic [COORD_W-1:0] rect_w_d, rect_w_q, rect_h_d, rect_h_q;
  logic [COUNT_W-1:0] pixel_count_d, pixel_count_q;
  logic               detected_d, detected_q;
  logic               frame_done_d, frame_done_q;

  always_comb begin
    vblnk_rise = vblnk_p1 & ~vblnk_prev_q;
    vblnk_fall = ~vblnk_p1 & vblnk_prev_q;
    pix_valid  = skin_p1 & ~hblnk_p1 & ~vblnk_p1 &
                 (hcount_p1 < H_LIM) & (vcount_p1 < V_LIM);
  end

  always_comb begin
    state_d       = state_q;
    min_x_d       = min_x_q;
    min_y_d       = min_y_q;
    max_x_d       = max_x_q;
    max_y_d       = max_y_q;
    count_d       = count_q;
    rect_x_d      = rect_x_q;
    rect_y_d      = rect_y_q;
    rect_w_d      = rect_w_q;
    rect_h_d      = rect_h_q;
    pixel_count_d = pixel_count_q;
    detected_d    = detected_q;
    frame_done_d  = 1'b0;

    case (state_q)
      // Only a vblank rising edge proves we are at a frame boundary.
      SYNC: begin
        if (vblnk_rise) state_d = ARMED;
      end
      ARMED: begin
        min_x_d = COORD_MAX;
        min_y_d = COORD_MAX;
        max_x_d = '0;
        max_y_d = '0;
        count_d = '0;
        if (vblnk_fall) state_d = ACCUM;
      end
      ACCUM: begin
        if (vblnk_rise) begin
          state_d = COMMIT;
        end else if (pix_valid) begin
          if (hcount_p1 < min_x_q) min_x_d = hcount_p1;
          if (hcount_p1 > max_x_q) max_x_d = hcount_p1;
          if (vcount_p1 < min_y_q) min_y_d = vcount_p1;
          if (vcount_p1 > max_y_q) max_y_d = vcount_p1;
          if (count_q != COUNT_MAX) count_d = count_q + 19'd1;
        end
      end
      COMMIT: begin
        frame_done_d  = 1'b1;
        pixel_count_d = count_q;
        state_d       = ARMED;
        if (count_q >= MIN_CNT) begin
          detected_d = 1'b1;
          rect_x_d   = min_x_q;
          rect_y_d   = min_y_q;
          rect_w_d   = span(min_x_q, max_x_q);
          rect_h_d   = span(min_y_q, max_y_q);
        end else begin
          detected_d = 1'b0;
        end
      end
      default: state_d = SYNC;
    endcase
  end

  // stage 1 -> stage 2 (accumulators carry no reset; ARMED clears them)
  always_ff @(posedge pclk) begin
    min_x_q <= min_x_d;
    min_y_q <= min_y_d;
    max_x_q <= max_x_d;
    max_y_q <= max_y_d;
    count_q <= count_d;
    if (!rst) begin
      state_q       <= SYNC;
      vblnk_prev_q  <= 1'b1;
      rect_x_q      <= '0;
      rect_y_q      <= '0;
      rect_w_q      <= '0;
      rect_h_q      <= '0;
      pixel_count_q <= '0;
      detected_q    <= 1'b0;
      frame_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      vblnk_prev_q  <= vblnk_p1;
      rect_x_q      <= rect_x_d;
      rect_y_q      <= rect_y_d;
      rect_w_q      <= rect_w_d;
      rect_h_q      <= rect_h_d;
      pixel_count_q <= pixel_count_d;
      detected_q    <= detected_d;
      frame_done_q  <= frame_done_d;
    end
  end

  assign rect_x        = rect_x_q;
  assign rect_y        = rect_y_q;
  assign rect_w        = rect_w_q;
  assign rect_h        = rect_h_q;
  assign pixel_count   = pixel_count_q;
  assign detected_flag = detected_q;
  assign frame_done    = frame_done_q;

endmodule

// File: tb/tb_face_bbox_tracker.sv
// Bench for face_bbox_tracker on a reduced 64x48 raster, two thresholds side by side.
module tb_face_bbox_tracker;

  localparam int HA = 64, VA = 48, HT = 72, VT = 52;
  localparam int MIN_A = 20, MIN_B = 1;

  logic        pclk = 1'b0;
  logic        rst = 1'b0;
  logic [10:0] hcount_in = '0, vcount_in = '0;
  logic        hblnk_in = 1'b0, vblnk_in = 1'b0;
  logic [11:0] rgb_in = '0;

  logic [10:0] a_x, a_y, a_w, a_h, b_x, b_y, b_w, b_h;
  logic [18:0] a_cnt, b_cnt;
  logic        a_det, b_det, a_fd, b_fd;

  face_bbox_tracker #(.H_ACTIVE(HA), .V_ACTIVE(VA), .MIN_PIXELS(MIN_A),
                      .R_MIN(6), .RG_MARGIN(2), .RB_MARGIN(3)) dut_a (
    .pclk(pclk), .rst(rst), .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hblnk_in(hblnk_in), .vblnk_in(vblnk_in), .rgb_in(rgb_in),
    .rect_x(a_x), .rect_y(a_y), .rect_w(a_w), .rect_h(a_h),
    .pixel_count(a_cnt), .detected_flag(a_det), .frame_done(a_fd));

  face_bbox_tracker #(.H_ACTIVE(HA), .V_ACTIVE(VA), .MIN_PIXELS(MIN_B),
                      .R_MIN(6), .RG_MARGIN(2), .RB_MARGIN(3)) dut_b (
    .pclk(pclk), .rst(rst), .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hblnk_in(hblnk_in), .vblnk_in(vblnk_in), .rgb_in(rgb_in),
    .rect_x(b_x), .rect_y(b_y), .rect_w(b_w), .rect_h(b_h),
    .pixel_count(b_cnt), .detected_flag(b_det), .frame_done(b_fd));

  always #5 pclk = ~pclk;

  int cyc = 0;
  always @(posedge pclk) cyc <= cyc + 1;

  int total = 0, bad = 0;
  int fd_cnt[2] = '{0, 0};
  int fd_last[2] = '{0, 0};
  int fd_snap[2] = '{0, 0};

  always @(negedge pclk) begin
    if (a_fd === 1'b1) begin fd_cnt[0] = fd_cnt[0] + 1; fd_last[0] = cyc; end
    if (b_fd === 1'b1) begin fd_cnt[1] = fd_cnt[1] + 1; fd_last[1] = cyc; end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // frame pattern
  logic [11:0] fg = '0, bg = '0, blk = '0;
  int rx0 = 1, rx1 = 0, ry0 = 1, ry1 = 0;
  bit noise = 1'b0;
  int rst_cycles = 0;

  // reference model: frame-level expectations for each instance
  int exp_v[2][6];
  int mnx, mny, mxx, mxy, mcnt;
  bit synced = 1'b0, pulse_exp = 1'b0;
  int vb_cyc = 0;
  int min_pix[2] = '{MIN_A, MIN_B};

  function automatic bit is_skin(input logic [11:0] p);
    int r, g, b;
    r = int'(p[11:8]); g = int'(p[7:4]); b = int'(p[3:0]);
    return (r >= 6) && (r > g + 2) && (r > b + 3);
  endfunction

  function automatic void model_clear();
    mnx = 2047; mny = 2047; mxx = 0; mxy = 0; mcnt = 0;
  endfunction

  function automatic void model_reset();
    synced = 1'b0;
    for (int d = 0; d < 2; d++)
      for (int f = 0; f < 6; f++) exp_v[d][f] = 0;
    model_clear();
  endfunction

  function automatic void model_step(input int h, input int v, input logic [11:0] p);
    if (h < HA && v < VA) begin
      if (is_skin(p)) begin
        if (h < mnx) mnx = h;
        if (h > mxx) mxx = h;
        if (v < mny) mny = v;
        if (v > mxy) mxy = v;
        mcnt++;
      end
    end else if (v == VA && h == 0) begin
      pulse_exp = synced;
      if (synced) begin
        for (int d = 0; d < 2; d++) begin
          exp_v[d][4] = mcnt;
          exp_v[d][5] = (mcnt >= min_pix[d]) ? 1 : 0;
          if (mcnt >= min_pix[d]) begin
            exp_v[d][0] = mnx;
            exp_v[d][1] = mny;
            exp_v[d][2] = mxx - mnx + 1;
            exp_v[d][3] = mxy - mny + 1;
          end
        end
      end
      synced = 1'b1;
      model_clear();
    end
  endfunction

  function automatic logic [11:0] pixel_at(input int h, input int v);
    if (h >= HA || v >= VA) return blk;
    if (h >= rx0 && h <= rx1 && v >= ry0 && v <= ry1) return fg;
    if (noise) return 12'($urandom);
    return bg;
  endfunction

  function automatic logic [31:0] obs(input int d, input int f);
    case (f)
      0: return 32'(d ? b_x : a_x);
      1: return 32'(d ? b_y : a_y);
      2: return 32'(d ? b_w : a_w);
      3: return 32'(d ? b_h : a_h);
      4: return 32'(d ? b_cnt : a_cnt);
      5: return 32'(d ? b_det : a_det);
      6: return 32'(fd_cnt[d] - fd_snap[d]);
      default: return 32'(fd_last[d] - vb_cyc);
    endcase
  endfunction

  function automatic logic [31:0] expv(input int d, input int f);
    if (f < 6) return 32'(exp_v[d][f]);
    if (f == 6) return {31'b0, pulse_exp};
    return 32'd3;
  endfunction

  function automatic string fname(input int f);
    case (f)
      0: return "rect_x";
      1: return "rect_y";
      2: return "rect_w";
      3: return "rect_h";
      4: return "pixel_count";
      5: return "detected_flag";
      6: return "frame_done_pulses";
      default: return "frame_done_latency";
    endcase
  endfunction

  // Drives n consecutive raster positions starting at (h0, v0); inputs change #1 after posedge.
  task automatic drive_px(input int v0, input int h0, input int n);
    int h, v;
    logic [11:0] px;
    h = h0; v = v0;
    for (int i = 0; i < n; i++) begin
      px = pixel_at(h, v);
      hcount_in = 11'(h);
      vcount_in = 11'(v);
      hblnk_in  = (h >= HA);
      vblnk_in  = (v >= VA);
      rgb_in    = px;
      if (rst_cycles > 0) begin
        rst = 1'b0;
        rst_cycles--;
        model_reset();
      end else begin
        rst = 1'b1;
        model_step(h, v, px);
      end
      if (v == VA && h == 0) vb_cyc = cyc;
      @(posedge pclk);
      #1;
      h++;
      if (h == HT) begin h = 0; v++; if (v == VT) v = 0; end
    end
  endtask

  task automatic set_block(input logic [11:0] c, input int x0, input int y0,
                           input int x1, input int y1);
    fg = c; rx0 = x0; ry0 = y0; rx1 = x1; ry1 = y1;
    bg = 12'h000; blk = 12'h000; noise = 1'b0;
  endtask

  task automatic test_reset();
    set_block(12'hA63, 0, 0, 63, 47);
    fd_snap = fd_cnt;
    rst_cycles = 4;
    drive_px(20, 0, 4);
    for (int d = 0; d < 2; d++)
      for (int f = 0; f < 6; f++) begin
        total++;
        if (obs(d, f) !== expv(d, f)) begin
          bad++;
          $display("FAIL reset dut%0d %s: got %0d want %0d", d, fname(f), obs(d, f), expv(d, f));
        end
      end
    drive_px(20, 4, (VT - 20) * HT - 4);
    for (int d = 0; d < 2; d++)
      for (int f = 0; f < 8; f++)
        if (f < 7 || pulse_exp) begin
          total++;
          if (obs(d, f) !== expv(d, f)) begin
            bad++;
            $display("FAIL partial_frame dut%0d %s: got %0d want %0d", d, fname(f), obs(d, f), expv(d, f));
          end
        end
  endtask

  task automatic test_frame(input string name);
    fd_snap = fd_cnt;
    drive_px(0, 0, HT * VT);
    for (int d = 0; d < 2; d++)
      for (int f = 0; f < 8; f++)
        if (f < 7 || pulse_exp) begin
          total++;
          if (obs(d, f) !== expv(d, f)) begin
            bad++;
            $display("FAIL %s dut%0d %s: got %0d want %0d", name, d, fname(f), obs(d, f), expv(d, f));
          end
        end
  endtask

  task automatic test_single_block();
    set_block(12'hA63, 10, 5, 29, 24);
    test_frame("single_block");
  endtask

  task automatic test_below_threshold();
    set_block(12'hA63, 40, 30, 43, 33);
    test_frame("below_threshold");
  endtask

  task automatic test_corner_pixel();
    set_block(12'hA63, HA - 1, VA - 1, HA - 1, VA - 1);
    test_frame("corner_pixel");
  endtask

  task automatic test_blanking();
    set_block(12'hA63, 1, 1, 0, 0);
    bg = 12'h883;
    blk = 12'hA63;
    test_frame("blanking");
  endtask

  task automatic test_reset_mid_frame();
    set_block(12'hA63, 10, 5, 29, 24);
    fd_snap = fd_cnt;
    drive_px(0, 0, 24 * HT);
    rst_cycles = 1;
    drive_px(24, 0, 1);
    for (int d = 0; d < 2; d++)
      for (int f = 0; f < 6; f++) begin
        total++;
        if (obs(d, f) !== expv(d, f)) begin
          bad++;
          $display("FAIL mid_reset dut%0d %s: got %0d want %0d", d, fname(f), obs(d, f), expv(d, f));
        end
      end
    drive_px(24, 1, (VT - 24) * HT - 1);
    for (int d = 0; d < 2; d++)
      for (int f = 0; f < 8; f++)
        if (f < 7 || pulse_exp) begin
          total++;
          if (obs(d, f) !== expv(d, f)) begin
            bad++;
            $display("FAIL mid_reset_vblank dut%0d %s: got %0d want %0d", d, fname(f), obs(d, f), expv(d, f));
          end
        end
    test_frame("after_mid_reset");
  endtask

  task automatic test_random_frames();
    for (int k = 0; k < 4; k++) begin
      int x0, y0;
      x0 = int'($urandom_range(0, HA - 1));
      y0 = int'($urandom_range(0, VA - 1));
      if ($urandom_range(0, 1) == 0)
        fg = {4'(10 + $urandom_range(0, 5)), 4'($urandom_range(0, 5)), 4'($urandom_range(0, 4))};
      else
        fg = 12'($urandom);
      rx0 = x0; ry0 = y0;
      rx1 = int'($urandom_range(x0, HA - 1));
      ry1 = int'($urandom_range(y0, VA - 1));
      bg    = 12'($urandom) & 12'h7FF;
      blk   = 12'($urandom);
      noise = ($urandom_range(0, 2) == 0);
      test_frame("random_frame");
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_block();
    test_below_threshold();
    test_corner_pixel();
    test_blanking();
    test_reset_mid_frame();
    test_random_frames();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
